// File: rtl/streaming_argmax_hs.sv
// Streaming argmax over NUM_CLASSES signed scores per frame, with ready/valid on both sides.
// Optional ARGMAX_MARGIN_EN adds second-max tracking and the out_margin port.
module streaming_argmax_hs #(
    parameter  int DATA_W      = 12,
    parameter  int NUM_CLASSES = 10,
    parameter  int TIE_LAST    = 0,
    localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic              gclk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
`ifdef ARGMAX_MARGIN_EN
    output logic [DATA_W:0]   out_margin,
`endif
    output logic [DATA_W-1:0] out_max
);

    localparam logic [IDX_W-1:0]         LAST_CNT = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic beats(input logic signed [DATA_W-1:0] cand,
                                   input logic signed [DATA_W-1:0] cur);
        if (TIE_LAST != 0) return cand >= cur;
        return cand > cur;
    endfunction

    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         run_idx_q, run_idx_d;
    logic [IDX_W-1:0]         out_idx_q, out_idx_d;
    logic signed [DATA_W-1:0] run_max_q, run_max_d;
    logic signed [DATA_W-1:0] out_max_q, out_max_d;
    logic signed [DATA_W-1:0] score, new_max;
    logic [IDX_W-1:0]         new_idx;
    logic                     out_valid_q, out_valid_d;
    logic                     last_beat, accept, replace, load;

`ifdef ARGMAX_MARGIN_EN
    function automatic logic [DATA_W:0] margin_of(input logic signed [DATA_W-1:0] mx,
                                                  input logic signed [DATA_W-1:0] sec);
        return {mx[DATA_W-1], mx} - {sec[DATA_W-1], sec};
    endfunction

    logic signed [DATA_W-1:0] sec_q, sec_d, new_sec;
    logic [DATA_W:0]          out_margin_q, out_margin_d;
`endif

    always_comb begin
        score     = signed'(in_data);
        last_beat = (cnt_q == LAST_CNT);
        // Only the frame-completing beat needs a free output slot.
        in_ready  = !(out_valid_q && !out_ready && last_beat);
        accept    = in_valid && in_ready && !clr;
        load      = accept && last_beat;
        replace   = (cnt_q == '0) || beats(score, run_max_q);
        new_max   = replace ? score : run_max_q;
        new_idx   = replace ? cnt_q : run_idx_q;

        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        out_idx_d   = out_idx_q;
        out_max_d   = out_max_q;
        out_valid_d = out_valid_q;
`ifdef ARGMAX_MARGIN_EN
        if (cnt_q == '0)          new_sec = MIN_VAL;
        else if (replace)         new_sec = run_max_q;
        else if (score > sec_q)   new_sec = score;
        else                      new_sec = sec_q;
        sec_d        = sec_q;
        out_margin_d = out_margin_q;
`endif

        if (clr) begin
            cnt_d     = '0;
            run_max_d = MIN_VAL;
            run_idx_d = '0;
`ifdef ARGMAX_MARGIN_EN
            sec_d     = MIN_VAL;
`endif
        end else if (accept) begin
            cnt_d     = last_beat ? '0 : cnt_q + 1'b1;
            run_max_d = new_max;
            run_idx_d = new_idx;
`ifdef ARGMAX_MARGIN_EN
            sec_d     = new_sec;
`endif
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = new_idx;
            out_max_d   = new_max;
`ifdef ARGMAX_MARGIN_EN
            out_margin_d = margin_of(new_max, new_sec);
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            run_max_q   <= MIN_VAL;
            run_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_max_q   <= '0;
`ifdef ARGMAX_MARGIN_EN
            sec_q        <= MIN_VAL;
            out_margin_q <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_max_q   <= out_max_d;
`ifdef ARGMAX_MARGIN_EN
            sec_q        <= sec_d;
            out_margin_q <= out_margin_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_max   = out_max_q;
`ifdef ARGMAX_MARGIN_EN
    assign out_margin = out_margin_q;
`endif

endmodule

// File: tb/tb_streaming_argmax_hs.sv
// Bench for streaming_argmax_hs: two instances (TIE_LAST 0 and 1) share one input stream.
module tb_streaming_argmax_hs;

    logic        gclk, rst_n, clr, in_valid, out_ready;
    logic [11:0] in_data;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [3:0]  out_idx0, out_idx1;
    logic signed [11:0] out_max0, out_max1;
`ifdef ARGMAX_MARGIN_EN
    logic [12:0] out_margin0, out_margin1;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    bit gaps_en = 0;

    streaming_argmax_hs #(.DATA_W(12), .NUM_CLASSES(10), .TIE_LAST(0)) u0 (
        .gclk(gclk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(out_margin0),
`endif
        .out_max(out_max0));

    streaming_argmax_hs #(.DATA_W(12), .NUM_CLASSES(10), .TIE_LAST(1)) u1 (
        .gclk(gclk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(out_margin1),
`endif
        .out_max(out_max1));

    initial gclk = 0;
    always #5 gclk = ~gclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [119:0] sc;
        int idx0;
        int idx1;
        int mx;
        int mg;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
    endtask

    function automatic logic [119:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7,
                                        input int a8, input int a9);
        logic [119:0] r;
        r = {a9[11:0], a8[11:0], a7[11:0], a6[11:0], a5[11:0],
             a4[11:0], a3[11:0], a2[11:0], a1[11:0], a0[11:0]};
        return r;
    endfunction

    // Reference: plain max, then first or last index holding it; margin against the
    // largest remaining score once one copy of the max is removed.
    function automatic void ref_model(input int s[10], input bit tie_last,
                                      output int idx, output int mx, output int mg);
        int sec;
        bit skipped;
        mx = s[0];
        for (int i = 1; i < 10; i++) if (s[i] > mx) mx = s[i];
        idx = -1;
        for (int i = 0; i < 10; i++)
            if (s[i] == mx && (tie_last || idx < 0)) idx = i;
        sec = -2048;
        skipped = 0;
        for (int i = 0; i < 10; i++) begin
            if (s[i] == mx && !skipped) skipped = 1;
            else if (s[i] > sec) sec = s[i];
        end
        mg = mx - sec;
    endfunction

    task automatic beat(input int v);
        int n;
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            in_valid = 0;
            repeat ($urandom_range(1, 2)) begin @(posedge gclk); #1; end
        end
        in_valid = 1;
        in_data  = 12'(v);
        n = 0;
        while (!in_ready0 && n < 50) begin @(posedge gclk); #1; n++; end
        if (n >= 50) chk("beat_ready_timeout", 0, 1);
        @(posedge gclk); #1;
        in_valid = 0;
    endtask

    task automatic run_frame(input int s[10], input int e_idx0, input int e_idx1,
                             input int e_max, input int e_mg, input string tag);
        for (int i = 0; i < 10; i++) beat(s[i]);
        chk({tag, "_valid"}, int'(out_valid0), 1);
        chk({tag, "_idx_tie0"}, int'(out_idx0), e_idx0);
        chk({tag, "_max_tie0"}, int'(out_max0), e_max);
        chk({tag, "_idx_tie1"}, int'(out_idx1), e_idx1);
        chk({tag, "_max_tie1"}, int'(out_max1), e_max);
`ifdef ARGMAX_MARGIN_EN
        chk({tag, "_margin_tie0"}, int'(out_margin0), e_mg);
        chk({tag, "_margin_tie1"}, int'(out_margin1), e_mg);
`endif
    endtask

    initial begin
        int s[10];
        int i0, i1, mx, mg;
        int fa[10], fb[10], fc[10], fe[10], ft[10];

        rst_n = 0; clr = 0; in_valid = 0; in_data = 0; out_ready = 1;
        #12;
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out_idx", int'(out_idx0), 0);
        chk("rst_out_max", int'(out_max0), 0);
        chk("rst_out_valid_tie1", int'(out_valid1), 0);
`ifdef ARGMAX_MARGIN_EN
        chk("rst_out_margin", int'(out_margin0), 0);
`endif
        @(posedge gclk); #1;
        rst_n = 1;

        tbl[0] = '{pk(5, -3, 100, 7, 0, 0, 0, 0, 0, -2048), 2, 2, 100, 93};
        tbl[1] = '{pk(-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, 2047), 9, 9, 2047, 3047};
        tbl[2] = '{pk(-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048), 0, 9, -2048, 0};
        tbl[3] = '{pk(0, 0, 0, 50, 0, 0, 0, 50, 0, 0), 3, 7, 50, 0};
        tbl[4] = '{pk(7, 6, 5, 4, 3, 2, 1, 0, -1, -2), 0, 0, 7, 1};

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 10; i++) begin
                logic signed [11:0] v;
                v = tbl[t].sc[i*12 +: 12];
                s[i] = v;
            end
            run_frame(s, tbl[t].idx0, tbl[t].idx1, tbl[t].mx, tbl[t].mg, $sformatf("tbl%0d", t));
            @(posedge gclk); #1;
            chk($sformatf("tbl%0d_drained", t), int'(out_valid0), 0);
        end

        gaps_en = 1;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 10; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0)      s[i] = -2048;
                else if (r == 1) s[i] = 2047;
                else if (r < 5)  s[i] = int'($urandom_range(0, 8)) - 4;
                else             s[i] = int'($urandom_range(0, 4095)) - 2048;
            end
            ref_model(s, 1'b0, i0, mx, mg);
            ref_model(s, 1'b1, i1, mx, mg);
            run_frame(s, i0, i1, mx, mg, $sformatf("rnd%0d", f));
        end
        gaps_en = 0;
        @(posedge gclk); #1;

        // Backpressure: A pending, B's first nine beats flow, B's last beat stalls.
        fa = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 5};
        fb = '{-5, -4, 300, -2, -1, 0, 1, 2, 3, 700};
        out_ready = 0;
        run_frame(fa, 8, 8, 90, 10, "bpA");
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("bp_mid_ready%0d", i), int'(in_ready0), 1);
            beat(fb[i]);
        end
        in_valid = 1;
        in_data  = 12'(fb[9]);
        #1;
        chk("bp_last_stalled", int'(in_ready0), 0);
        repeat (3) begin @(posedge gclk); #1; end
        chk("bp_still_stalled", int'(in_ready0), 0);
        chk("bp_hold_valid", int'(out_valid0), 1);
        chk("bp_hold_idx", int'(out_idx0), 8);
        chk("bp_hold_max", int'(out_max0), 90);
        out_ready = 1;
        #1;
        chk("bp_ready_follows_out_ready", int'(in_ready0), 1);
        @(posedge gclk); #1;
        in_valid = 0;
        chk("bpB_valid", int'(out_valid0), 1);
        chk("bpB_idx", int'(out_idx0), 9);
        chk("bpB_max", int'(out_max0), 700);
        chk("bpB_idx_tie1", int'(out_idx1), 9);
`ifdef ARGMAX_MARGIN_EN
        chk("bpB_margin", int'(out_margin0), 400);
`endif
        @(posedge gclk); #1;
        chk("bpB_consumed", int'(out_valid0), 0);

        // Abort a partial frame of large scores while a result is pending.
        fc = '{-100, -50, -20, -30, -10, -60, -70, -80, -90, -40};
        fe = '{10, 20, 30, 40, 50, 300, 60, 70, 80, 90};
        out_ready = 0;
        run_frame(fc, 4, 4, -10, 10, "clrC");
        for (int i = 0; i < 4; i++) beat(2000);
        clr = 1; in_valid = 1; in_data = 12'(2047);
        @(posedge gclk); #1;
        clr = 0; in_valid = 0;
        chk("clr_keeps_valid", int'(out_valid0), 1);
        chk("clr_keeps_idx", int'(out_idx0), 4);
        chk("clr_keeps_max", int'(out_max0), -10);
        out_ready = 1;
        run_frame(fe, 5, 5, 300, 210, "clrE");
        @(posedge gclk); #1;

        // Asynchronous reset with a pending result and cnt at 6.
        out_ready = 0;
        run_frame(fa, 8, 8, 90, 10, "rstA");
        for (int i = 0; i < 6; i++) beat(i + 1);
        rst_n = 0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid0), 0);
        chk("rst_mid_in_ready", int'(in_ready0), 1);
        chk("rst_mid_out_idx", int'(out_idx0), 0);
        chk("rst_mid_out_max", int'(out_max0), 0);
        @(posedge gclk); #1;
        rst_n = 1;
        out_ready = 1;
        ft = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        run_frame(ft, 5, 5, 9, 3, "rstT");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
